image_frame_buffer: RTL and testbench

//  Ping-pong (2-bank) frame store feeding the Sobel window stage. Accepts a raster pixel stream, or self-fills
//  a selectable test pattern, into the write bank. Serves 1-cycle-latency random reads from the other, completed bank.
//  Out-of-image reads return 0, giving zero-padded borders for 3x3 kernels.

---
 rtl/image_frame_buffer.sv | 135 +++++++++++++
 tb/tb_image_frame_buffer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/image_frame_buffer.sv
// Two-bank ping-pong frame store: stream or pattern fill into the write bank,
// 1-cycle random reads (zero outside the image) from the completed read bank.
module image_frame_buffer #(
    parameter  int IMG_WIDTH  = 8,
    parameter  int IMG_HEIGHT = 8,
    parameter  int DATA_WIDTH = 8,
    localparam int CW         = $clog2(IMG_WIDTH),
    localparam int RW         = $clog2(IMG_HEIGHT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    input  logic                  pat_start,
    input  logic [1:0]            pat_sel,
    output logic                  fill_busy,
    output logic                  frame_done,
    output logic                  rd_frame_valid,
    input  logic                  rd_en,
    input  logic [RW:0]           rd_row,
    input  logic [CW:0]           rd_col,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_pixel,
    input  logic                  rd_release
);
    localparam int NPIX = IMG_WIDTH * IMG_HEIGHT;
    localparam int AW   = $clog2(2 * NPIX);
    localparam logic [DATA_WIDTH-1:0] MAXV = {DATA_WIDTH{1'b1}};

    typedef enum logic [1:0] {ACCEPT, FILL, WAIT} wr_state_t;

    wr_state_t             state;
    logic                  wr_bank, rd_bank;
    logic [1:0]            full, full_nxt;
    logic [RW-1:0]         wr_row;
    logic [CW-1:0]         wr_col;
    logic [1:0]            pat_q;
    logic [DATA_WIDTH-1:0] pat_px, wr_px;
    logic                  pat_accept, wr_en, last_px, rel, rd_accept, rd_in;
    logic [AW-1:0]         wr_addr, rd_addr;

    logic [DATA_WIDTH-1:0] mem [0:2*NPIX-1];

    function automatic logic [AW-1:0] pix_addr(input logic b, input logic [RW-1:0] r,
                                               input logic [CW-1:0] c);
        return AW'(b) * AW'(NPIX) + AW'(r) * AW'(IMG_WIDTH) + AW'(c);
    endfunction

    assign wr_ready   = !rst && state == ACCEPT && !full[wr_bank];
    // A pattern request wins over a coincident stream pixel so the fill starts at (0,0).
    assign pat_accept = pat_start && state == ACCEPT && !full[wr_bank] &&
                        wr_row == '0 && wr_col == '0;
    assign wr_en      = (wr_valid && wr_ready && !pat_accept) || state == FILL;
    assign last_px    = wr_row == RW'(IMG_HEIGHT - 1) && wr_col == CW'(IMG_WIDTH - 1);
    assign wr_px      = (state == FILL) ? pat_px : wr_data;
    assign wr_addr    = pix_addr(wr_bank, wr_row, wr_col);

    assign rd_frame_valid = full[rd_bank];
    assign rel            = rd_release && full[rd_bank];
    assign rd_accept      = rd_en && full[rd_bank];
    assign rd_in          = !rd_row[RW] && !rd_col[CW] &&
                            32'(rd_row[RW-1:0]) < IMG_HEIGHT &&
                            32'(rd_col[CW-1:0]) < IMG_WIDTH;
    assign rd_addr        = pix_addr(rd_bank, rd_row[RW-1:0], rd_col[CW-1:0]);

    always_comb begin
        pat_px = '0;
        case (pat_q)
            2'd0:    pat_px = DATA_WIDTH'(32'(wr_row) * 32'(wr_col));
            2'd1:    pat_px = DATA_WIDTH'(32'(wr_row) + 32'(wr_col));
            2'd2:    pat_px = (wr_row[0] ^ wr_col[0]) ? MAXV : '0;
            default: pat_px = (32'(wr_row) < IMG_HEIGHT / 2) ? '0 : MAXV;
        endcase
    end

    // Completion and release always target different banks, so both can apply at once.
    always_comb begin
        full_nxt = full;
        if (wr_en && last_px) full_nxt[wr_bank] = 1'b1;
        if (rel)              full_nxt[rd_bank] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_px;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ACCEPT;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            full       <= 2'b00;
            wr_row     <= '0;
            wr_col     <= '0;
            pat_q      <= 2'd0;
            fill_busy  <= 1'b0;
            frame_done <= 1'b0;
            rd_valid   <= 1'b0;
            rd_pixel   <= '0;
        end else begin
            frame_done <= 1'b0;
            full       <= full_nxt;
            rd_valid   <= rd_accept;
            if (rel)       rd_bank  <= ~rd_bank;
            if (rd_accept) rd_pixel <= rd_in ? mem[rd_addr] : '0;

            if (wr_en) begin
                if (last_px) begin
                    wr_row     <= '0;
                    wr_col     <= '0;
                    wr_bank    <= ~wr_bank;
                    frame_done <= 1'b1;
                    fill_busy  <= 1'b0;
                    state      <= full_nxt[~wr_bank] ? WAIT : ACCEPT;
                end else if (wr_col == CW'(IMG_WIDTH - 1)) begin
                    wr_col <= '0;
                    wr_row <= wr_row + RW'(1);
                end else begin
                    wr_col <= wr_col + CW'(1);
                end
            end

            case (state)
                ACCEPT: if (pat_accept) begin
                    pat_q     <= pat_sel;
                    state     <= FILL;
                    fill_busy <= 1'b1;
                end
                WAIT:   if (!full_nxt[wr_bank]) state <= ACCEPT;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_image_frame_buffer.sv
// Randomized bench for image_frame_buffer: a queue of completed frames models
// the ping-pong banks; every read and handshake is checked against it.
module tb_image_frame_buffer;
    localparam int W = 8, H = 8, DW = 8, NP = W * H;
    typedef logic [NP*DW-1:0] frame_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_valid = 1'b0, wr_ready;
    logic [DW-1:0] wr_data = '0;
    logic          pat_start = 1'b0;
    logic [1:0]    pat_sel = 2'd0;
    logic          fill_busy, frame_done, rd_frame_valid;
    logic          rd_en = 1'b0, rd_release = 1'b0, rd_valid;
    logic [3:0]    rd_row = '0, rd_col = '0;
    logic [DW-1:0] rd_pixel;

    image_frame_buffer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .pat_start(pat_start), .pat_sel(pat_sel), .fill_busy(fill_busy),
        .frame_done(frame_done), .rd_frame_valid(rd_frame_valid), .rd_en(rd_en),
        .rd_row(rd_row), .rd_col(rd_col), .rd_valid(rd_valid), .rd_pixel(rd_pixel),
        .rd_release(rd_release));

    always #5 clk = ~clk;

    int            n_tests = 0, n_fail = 0;
    frame_t        done_q[$];
    frame_t        cur = '0;
    int            wr_idx = 0;
    logic [DW-1:0] last_pix = '0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] ref_pix(input int r, input int c);
        frame_t f;
        if (r < 0 || r >= H || c < 0 || c >= W || done_q.size() == 0) return '0;
        f = done_q[0];
        return f[(r*W+c)*DW +: DW];
    endfunction

    function automatic logic [DW-1:0] ref_pat(input int sel, input int r, input int c);
        case (sel)
            0:       return DW'((r * c) % 256);
            1:       return DW'((r + c) % 256);
            2:       return (((r ^ c) & 1) != 0) ? 8'hFF : 8'h00;
            default: return (r < H / 2) ? 8'h00 : 8'hFF;
        endcase
    endfunction

    task automatic do_reset;
        rst = 1'b1; wr_valid = 1'b0; pat_start = 1'b0; rd_en = 1'b0; rd_release = 1'b0;
        tick;
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_pixel", rd_pixel, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_fill_busy", fill_busy, 0);
        chk("rst_rd_frame_valid", rd_frame_valid, 0);
        rst = 1'b0;
        done_q.delete();
        wr_idx = 0;
        last_pix = '0;
        #1;
        chk("post_rst_ready", wr_ready, 1);
    endtask

    task automatic stream_px(input int n, input bit idx_data);
        int bad;
        logic [DW-1:0] d;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            d = idx_data ? DW'(wr_idx) : DW'($urandom);
            if (wr_ready !== 1'b1) bad++;
            wr_valid = 1'b1; wr_data = d;
            cur[wr_idx*DW +: DW] = d;
            tick;
            if (wr_idx == NP - 1) begin
                chk("frame_done", frame_done, 1);
                done_q.push_back(cur);
                wr_idx = 0;
            end else begin
                if (frame_done !== 1'b0) bad++;
                wr_idx++;
            end
        end
        wr_valid = 1'b0;
        chk("stream_handshake", bad, 0);
    endtask

    task automatic fill(input int sel);
        int n, bad;
        frame_t f;
        n = 0; bad = 0;
        pat_sel = 2'(sel); pat_start = 1'b1;
        tick;
        pat_start = 1'b0;
        chk("fill_busy_on", fill_busy, 1);
        wr_valid = 1'b1;   // stray stream traffic during the fill must be ignored
        while (n < 200) begin
            wr_data = DW'($urandom);
            if (wr_ready !== 1'b0 || fill_busy !== 1'b1) bad++;
            tick;
            n++;
            if (frame_done === 1'b1) break;
        end
        wr_valid = 1'b0;
        chk("fill_len", n, NP);
        chk("fill_busy_off", fill_busy, 0);
        chk("fill_flags", bad, 0);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                f[(r*W+c)*DW +: DW] = ref_pat(sel, r, c);
        done_q.push_back(f);
    endtask

    task automatic rd(input int r, input int c, input string tag);
        logic exp_v;
        logic [DW-1:0] exp_p;
        exp_v = done_q.size() > 0;
        exp_p = exp_v ? ref_pix(r, c) : last_pix;
        rd_en = 1'b1; rd_row = 4'(r); rd_col = 4'(c);
        tick;
        rd_en = 1'b0;
        chk({tag, "_valid"}, rd_valid, exp_v);
        chk({tag, "_pixel"}, rd_pixel, exp_p);
        last_pix = exp_p;
    endtask

    task automatic rand_reads(input int n);
        for (int i = 0; i < n; i++)
            rd(int'($urandom_range(0, 11)) - 2, int'($urandom_range(0, 11)) - 2, "rand_rd");
    endtask

    // Optional read in the same cycle as the release must still see the old bank.
    task automatic release_bank(input bit with_read, input int r, input int c);
        logic [DW-1:0] exp_p;
        exp_p = ref_pix(r, c);
        rd_release = 1'b1;
        if (with_read) begin
            rd_en = 1'b1; rd_row = 4'(r); rd_col = 4'(c);
        end
        tick;
        rd_release = 1'b0; rd_en = 1'b0;
        if (with_read) begin
            chk("rel_rd_valid", rd_valid, 1);
            chk("rel_rd_pixel", rd_pixel, exp_p);
            last_pix = exp_p;
        end
        if (done_q.size() > 0) void'(done_q.pop_front());
        chk("rel_wr_ready", wr_ready, done_q.size() < 2);
        chk("rel_frame_valid", rd_frame_valid, done_q.size() > 0);
    endtask

    initial begin
        int bad;
        do_reset;

        // pattern 0 fill and reads
        fill(0);
        rd(3, 5, "p0_3_5");
        chk("p0_3_5_const", rd_pixel, 15);
        rd(7, 7, "p0_7_7");
        chk("p0_7_7_const", rd_pixel, 49);
        rand_reads(16);
        rd(0, 0, "p0_0_0");
        release_bank(0, 0, 0);

        // index stream, border reads, read coincident with release
        stream_px(NP, 1'b1);
        rd(2, 3, "s_2_3");
        chk("s_2_3_const", rd_pixel, 19);
        rd(7, 7, "s_7_7");
        chk("s_7_7_const", rd_pixel, 63);
        rd(-1, 0, "bord_a");
        rd(0, 8, "bord_b");
        rd(8, 3, "bord_c");
        rd(0, -1, "bord_d");
        rd(0, 0, "s_0_0");
        release_bank(1'b1, 4, 4);

        // remaining patterns
        fill(2);
        rd(0, 0, "p2_0_0");
        rd(0, 1, "p2_0_1");
        rand_reads(8);
        release_bank(0, 0, 0);
        fill(1);
        rand_reads(8);
        release_bank(0, 0, 0);
        fill(3);
        rand_reads(8);
        rd(3, 0, "p3_3_0");
        rd(4, 7, "p3_4_7");
        release_bank(0, 0, 0);

        // both banks full -> WAIT, stream ignored until a release
        stream_px(NP, 1'b0);
        stream_px(NP, 1'b0);
        chk("wait_ready", wr_ready, 0);
        bad = 0;
        wr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_data = DW'($urandom);
            tick;
            if (wr_ready !== 1'b0 || frame_done !== 1'b0) bad++;
        end
        wr_valid = 1'b0;
        chk("wait_hold", bad, 0);
        rand_reads(8);
        release_bank(0, 0, 0);
        rand_reads(8);
        release_bank(1'b1, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));

        // no readable frame; pattern request mid-stream is ignored
        rd(2, 2, "nofr");
        stream_px(10, 1'b0);
        pat_sel = 2'd0; pat_start = 1'b1;
        tick;
        pat_start = 1'b0;
        chk("midpat_busy", fill_busy, 0);
        chk("midpat_ready", wr_ready, 1);
        stream_px(NP - 10, 1'b0);
        rand_reads(8);
        rd(0, 0, "mid_0_0");
        release_bank(0, 0, 0);

        // reset mid-frame discards the partial frame
        stream_px(30, 1'b0);
        do_reset;
        stream_px(NP, 1'b0);
        rd(0, 0, "rst_new_0_0");
        rand_reads(8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
